rr_scan_mux: RTL and testbench

RR_SCAN_MUX -- requirements
Module: rr_scan_mux

---
 rtl/rr_scan_mux.sv | 126 ++++++++++++
 tb/tb_rr_scan_mux.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_scan_mux.sv
// rtl/rr_scan_mux.sv - registered N-channel mux with manual select and dwell-timed round-robin scan
// Auto-scan (SCAN state, dwell counter, scan channel) is built only when RR_SCAN_MUX_AUTOSCAN_EN is defined.
module rr_scan_mux #(
    parameter int N_CH    = 4,
    parameter int W       = 4,
    parameter int DWELL_W = 8,
    localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic [DWELL_W-1:0]  dwell,
    input  logic [N_CH*W-1:0]   data_in,
    output logic [W-1:0]        out_data,
    output logic [SEL_W-1:0]    out_ch,
    output logic                out_valid
);

    localparam logic [SEL_W:0] N_CH_EXT = (SEL_W+1)'(N_CH);

    function automatic logic [W-1:0] pick(input logic [N_CH*W-1:0] bus, input logic [SEL_W-1:0] idx);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (idx == k[SEL_W-1:0]) r = bus[k*W +: W];
        end
        return r;
    endfunction

    logic           man_valid;
    logic [W-1:0]   man_data;
    logic [W-1:0]   data_d;
    logic [SEL_W-1:0] och_d;
    logic           valid_d;

    // Indices past the last channel only exist for non-power-of-two N_CH.
    assign man_valid = ({1'b0, sel} < N_CH_EXT);
    assign man_data  = man_valid ? pick(data_in, sel) : '0;

`ifdef RR_SCAN_MUX_AUTOSCAN_EN
    typedef enum logic {MANUAL, SCAN} state_t;

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d, cur_cnt;
    logic [SEL_W-1:0]   ch_q, ch_d, cur_ch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MANUAL;
            cnt_q   <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        cur_cnt = cnt_q;
        cur_ch  = ch_q;
        data_d  = out_data;
        och_d   = out_ch;
        valid_d = 1'b0;
        if (ena) begin
            state_d = mode ? SCAN : MANUAL;
            if (state_d == SCAN) begin
                // The edge that enters SCAN already outputs channel 0 at count 0.
                if (state_q == MANUAL) begin
                    cur_cnt = '0;
                    cur_ch  = '0;
                end
                data_d  = pick(data_in, cur_ch);
                och_d   = cur_ch;
                valid_d = (cur_cnt == dwell);
                if (cur_cnt == dwell) begin
                    cnt_d = '0;
                    ch_d  = (cur_ch == LAST_CH) ? '0 : cur_ch + 1'b1;
                end else begin
                    cnt_d = cur_cnt + 1'b1;
                end
            end else begin
                cnt_d   = '0;
                ch_d    = '0;
                data_d  = man_data;
                och_d   = sel;
                valid_d = man_valid;
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{mode, dwell};

    always_comb begin
        data_d  = out_data;
        och_d   = out_ch;
        valid_d = 1'b0;
        if (ena) begin
            data_d  = man_data;
            och_d   = sel;
            valid_d = man_valid;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_data  <= data_d;
            out_ch    <= och_d;
            out_valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_rr_scan_mux.sv
// tb/tb_rr_scan_mux.sv - directed and randomized checks of rr_scan_mux against a behavioural model
module tb_rr_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        mode = 1'b0;
    logic [1:0]  sel = '0;
    logic [7:0]  dwell = '0;
    logic [15:0] data_in = '0;
    logic [3:0]  out_data, out_data3;
    logic [1:0]  out_ch, out_ch3;
    logic        out_valid, out_valid3;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    bit m_scan = 0;
    int m_ch = 0;
    int m_cnt = 0;
    int e_data = 0, e_ch = 0, e_valid = 0;

`ifdef RR_SCAN_MUX_AUTOSCAN_EN
    localparam bit AUTOSCAN = 1'b1;
`else
    localparam bit AUTOSCAN = 1'b0;
`endif

    rr_scan_mux #(.N_CH(4), .W(4), .DWELL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .sel(sel), .dwell(dwell),
        .data_in(data_in), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid)
    );

    rr_scan_mux #(.N_CH(3), .W(4), .DWELL_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .sel(sel), .dwell(dwell),
        .data_in(data_in[11:0]), .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int chan(input int k);
        return (int'(data_in) >> (k * 4)) & 15;
    endfunction

    task automatic model_reset();
        m_scan = 0; m_ch = 0; m_cnt = 0;
        e_data = 0; e_ch = 0; e_valid = 0;
    endtask

    task automatic model_edge();
        if (!ena) begin
            e_valid = 0;
        end else if (AUTOSCAN && mode) begin
            if (!m_scan) begin m_ch = 0; m_cnt = 0; end
            m_scan  = 1;
            e_data  = chan(m_ch);
            e_ch    = m_ch;
            e_valid = (m_cnt == int'(dwell)) ? 1 : 0;
            if (m_cnt == int'(dwell)) begin
                m_cnt = 0;
                m_ch  = (m_ch + 1) % 4;
            end else begin
                m_cnt = (m_cnt + 1) % 256;
            end
        end else begin
            m_scan = 0; m_ch = 0; m_cnt = 0;
            e_ch = int'(sel);
            e_data = chan(int'(sel));
            e_valid = 1;
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".data"}, 32'(out_data), 32'(e_data));
        check({tag, ".ch"}, 32'(out_ch), 32'(e_ch));
        check({tag, ".valid"}, 32'(out_valid), 32'(e_valid));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outs(tag);
    endtask

    int pulse_ch[$];
    int pulse_dat[$];
    int first_pulse;
    int saved_ch, saved_data;

    initial begin
        // Reset state
        #2;
        check("rst.data", 32'(out_data), 0);
        check("rst.ch", 32'(out_ch), 0);
        check("rst.valid", 32'(out_valid), 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Manual select of channel 2
        ena = 1; mode = 0; sel = 2; data_in = 16'hDCBA;
        step("man_sel2");
        check("man_sel2.c", {out_data, 2'b00, out_ch, 3'b000, out_valid}, {4'hC, 2'b00, 2'd2, 3'b000, 1'b1});

        // N_CH=3 instance with an out-of-range index
        sel = 3;
        step("man_sel3");
        check("n3_sel3.data", 32'(out_data3), 0);
        check("n3_sel3.ch", 32'(out_ch3), 3);
        check("n3_sel3.valid", 32'(out_valid3), 0);
        sel = 1;
        step("man_sel1");
        check("n3_sel1.data", 32'(out_data3), 32'hB);
        check("n3_sel1.valid", 32'(out_valid3), 1);

        if (AUTOSCAN) begin
            // dwell=2: pulse every third cycle, channels 0..3,0
            mode = 1; dwell = 2;
            for (int i = 0; i < 15; i++) begin
                step("scan_d2");
                check("scan_d2.spacing", 32'(out_valid), 32'((i % 3) == 2));
                if (out_valid) begin
                    pulse_ch.push_back(int'(out_ch));
                    pulse_dat.push_back(int'(out_data));
                end
            end
            check("scan_d2.npulse", 32'(pulse_ch.size()), 5);
            for (int i = 0; i < pulse_ch.size() && i < 5; i++) begin
                check("scan_d2.pch", 32'(pulse_ch[i]), 32'(i % 4));
                check("scan_d2.pdat", 32'(pulse_dat[i]), 32'(10 + (i % 4)));
            end

            // dwell=0 from a fresh scan start
            mode = 0; step("to_man");
            mode = 1; dwell = 0;
            for (int i = 0; i < 6; i++) begin
                step("scan_d0");
                check("scan_d0.ch", 32'(out_ch), 32'(i % 4));
                check("scan_d0.valid", 32'(out_valid), 1);
            end

            // Lowering dwell below the count waits for the counter to wrap
            mode = 0; step("to_man2");
            mode = 1; dwell = 4;
            for (int i = 0; i < 3; i++) step("lower_pre");
            dwell = 1;
            first_pulse = -1;
            for (int i = 1; i <= 258; i++) begin
                step("lower");
                if (out_valid && first_pulse < 0) first_pulse = i;
            end
            check("lower.first_pulse", 32'(first_pulse), 255);

            // ena low for 5 cycles mid-scan
            mode = 0; step("to_man3");
            mode = 1; dwell = 3;
            for (int i = 0; i < 6; i++) step("ena_pre");
            saved_ch = e_ch; saved_data = e_data;
            ena = 0;
            for (int i = 0; i < 5; i++) begin
                step("ena_off");
                check("ena_off.valid", 32'(out_valid), 0);
                check("ena_off.ch_held", 32'(out_ch), 32'(saved_ch));
                check("ena_off.data_held", 32'(out_data), 32'(saved_data));
            end
            ena = 1;
            for (int i = 0; i < 8; i++) step("ena_resume");

            // Async reset at channel 3, count 1
            dwell = 2;
            for (int i = 0; i < 40 && !(m_ch == 3 && m_cnt == 1); i++) step("rst_seek");
            check("rst_seek.reached", 32'(m_ch == 3 && m_cnt == 1), 1);
            #3 rst_n = 0;
            model_reset();
            #1;
            check_outs("rst_async");
            @(posedge clk); #1;
            check_outs("rst_hold");
            rst_n = 1;
            step("rst_resume0");
            check("rst_resume.ch", 32'(out_ch), 0);
            for (int i = 0; i < 4; i++) step("rst_resume");
        end else begin
            // Without auto-scan, mode=1 still yields manual output
            mode = 1; dwell = 0; sel = 1;
            step("noscan_sel1");
            check("noscan.data", 32'(out_data), 32'hB);
            check("noscan.ch", 32'(out_ch), 1);
            ena = 0;
            step("noscan_ena_off");
            ena = 1;
            #3 rst_n = 0;
            model_reset();
            #1;
            check_outs("rst_async");
            @(posedge clk); #1;
            rst_n = 1;
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            ena     = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            sel     = 2'($urandom_range(0, 3));
            dwell   = 8'($urandom_range(0, 3));
            data_in = 16'($urandom);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
